spi_flash_responder: RTL

- SPI mode-0 target that emulates a serial flash READ (0x03) responder: the far end of the team's SPI flash-read initiator.
- Used as a bench/FPGA stand-in for the external flash. It oversamples SCLK/CS_N/MOSI in the system clock domain.
- Decodes an 8-bit command and a 24-bit big-endian address, then streams bytes from a synchronous byte memory on MISO, MSB first, auto-incrementing the address until CS_N rises.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_in_sync.sv | 37 +++
 rtl/spi_flash_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash-read responder: FSM encoding, opcodes
// and frame field widths.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_FETCH,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

endpackage

// File: rtl/spi_in_sync.sv
// Brings the asynchronous SPI pins into clk: two-flop synchronizers on all
// three, plus a third sclk flop so rising/falling edges can be detected.
module spi_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // sclk_q[1] is the synchronized level, sclk_q[2] its previous value
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s    = cs_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial flash READ responder backed by a
// synchronous byte memory. Define FAST_READ_EN to also accept 0x0B + dummy byte.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cs_n high, waiting for select
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit address (only low ADDR_W bits kept)
// ST_DUMMY  | fast read only: 8 ignored clocks before the first fetch
// ST_FETCH  | first memory read in flight (mem_rd, then latch mem_data)
// ST_DATA   | streaming bytes on miso, prefetching the next byte
// ST_IGNORE | unsupported opcode, waiting for cs_n high
module spi_flash_responder #(
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              cmd_err
);
  import spi_pkg::*;

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;

  spi_in_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s)
  );

  state_t            state, state_n;
  logic [4:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        cmd_sr, cmd_sr_n;
  logic [ADDR_W-1:0] addr_sr, addr_sr_n;
  logic [7:0]        tx_sr, tx_sr_n;
  logic [7:0]        pend, pend_n;
  logic              load_pend, load_pend_n;
  logic              fast, fast_n;
  logic              rd_d;
  logic              miso_oe_n, mem_rd_n, cmd_err_n;
  logic [ADDR_W-1:0] mem_addr_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      tx_sr     <= '0;
      pend      <= '0;
      load_pend <= 1'b0;
      fast      <= 1'b0;
      rd_d      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      cmd_sr    <= cmd_sr_n;
      addr_sr   <= addr_sr_n;
      tx_sr     <= tx_sr_n;
      pend      <= pend_n;
      load_pend <= load_pend_n;
      fast      <= fast_n;
      rd_d      <= mem_rd;
      miso_oe   <= miso_oe_n;
      mem_rd    <= mem_rd_n;
      mem_addr  <= mem_addr_n;
      cmd_err   <= cmd_err_n;
      busy      <= ~cs_n_s;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    cmd_sr_n    = cmd_sr;
    addr_sr_n   = addr_sr;
    tx_sr_n     = tx_sr;
    pend_n      = pend;
    load_pend_n = load_pend;
    fast_n      = fast;
    mem_rd_n    = 1'b0;
    mem_addr_n  = mem_addr;
    cmd_err_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!cs_n_s) begin
          state_n   = ST_CMD;
          bit_cnt_n = '0;
          fast_n    = 1'b0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          cmd_sr_n  = {cmd_sr[6:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(CMD_BITS - 1)) begin
            bit_cnt_n = '0;
            if (cmd_sr_n == CMD_READ) begin
              state_n = ST_ADDR;
`ifdef FAST_READ_EN
            end else if (cmd_sr_n == CMD_FAST_READ) begin
              state_n = ST_ADDR;
              fast_n  = 1'b1;
`endif
            end else begin
              cmd_err_n = 1'b1;
              state_n   = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          // Upper address bits simply shift out of the ADDR_W-wide register
          addr_sr_n = {addr_sr[ADDR_W-2:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(ADDR_BITS - 1)) begin
            bit_cnt_n = '0;
            if (fast) begin
              state_n = ST_DUMMY;
            end else begin
              state_n    = ST_FETCH;
              mem_rd_n   = 1'b1;
              mem_addr_n = addr_sr_n;
            end
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_rise) begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(CMD_BITS - 1)) begin
            bit_cnt_n  = '0;
            state_n    = ST_FETCH;
            mem_rd_n   = 1'b1;
            mem_addr_n = addr_sr;
          end
        end
      end
      ST_FETCH: begin
        if (rd_d) begin
          pend_n      = mem_data;
          load_pend_n = 1'b1;
          bit_cnt_n   = '0;
          state_n     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sclk_fall) begin
          if (load_pend) begin
            tx_sr_n     = pend;
            load_pend_n = 1'b0;
          end else begin
            tx_sr_n = {tx_sr[6:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          if (bit_cnt == 5'd7) begin
            bit_cnt_n  = '0;
            mem_addr_n = mem_addr + 1'b1;
            mem_rd_n   = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
        // Prefetched byte arrives the clk after the read strobe ends
        if (rd_d) begin
          pend_n      = mem_data;
          load_pend_n = 1'b1;
        end
      end
      ST_IGNORE: begin
      end
      default: state_n = ST_IDLE;
    endcase

    // Deselect wins over everything, including a coincident sclk fall
    if (state != ST_IDLE && cs_n_s) begin
      state_n     = ST_IDLE;
      bit_cnt_n   = '0;
      tx_sr_n     = tx_sr;
      load_pend_n = 1'b0;
      mem_rd_n    = 1'b0;
      cmd_err_n   = 1'b0;
    end

    miso_oe_n = (state_n == ST_DATA);
  end

  assign miso = tx_sr[7];

endmodule
